// File: rtl/fx_mul_arbiter.sv
// fx_mul_arbiter
//   Shares one signed 16x16 fixed-point multiplier among N_REQ requesters.
//   Round-robin arbitration picks one requester per cycle. Its operands are
//   captured into stage S1. Stage S2 then holds the product, shifted right
//   arithmetically by SHIFT and saturated to 16 bits. A new operation can
//   issue on every cycle.
//
// Ports
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_req    per-requester request, held high until o_gnt is seen
//   i_a/i_b  packed signed operands, requester k at [16k+15:16k]
//   o_gnt    one-hot, one cycle: requester's operands captured (S1 owner)
//   o_ack    one-hot, one cycle: o_result holds that requester's result (S2 owner)
//   o_result scaled, saturated product; holds its value when S2 is idle
//   o_busy   S1 valid or S2 valid
module fx_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int SHIFT = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [16*N_REQ-1:0]  i_a,
  input  logic [16*N_REQ-1:0]  i_b,
  output logic [N_REQ-1:0]     o_gnt,
  output logic [N_REQ-1:0]     o_ack,
  output logic [15:0]          o_result,
  output logic                 o_busy
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Stage S1. o_gnt is the registered one-hot of the S1 owner, so it also
  // serves as the S1 ownership mask.
  logic                s1_valid;
  logic [IDW-1:0]      s1_owner;
  logic signed [15:0]  s1_a;
  logic signed [15:0]  s1_b;

  logic [IDW-1:0]      ptr;

  logic [N_REQ-1:0]    eligible;
  logic                win_found;
  logic [IDW-1:0]      win_idx;
  int unsigned         cand;
  logic [15:0]         win_a;
  logic [15:0]         win_b;

  logic signed [31:0]  prod;
  logic signed [31:0]  shifted;
  logic [15:0]         sat;

  // The requester whose operation sits in S1 must not win again at this edge.
  // A requester that holds i_req high therefore re-wins two edges later at
  // the earliest.
  assign eligible = i_req & ~o_gnt;

  // Round-robin search that starts one past the last winner and wraps.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (32'(ptr) + i) % N_REQ;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    win_a = i_a[32'(win_idx)*16 +: 16];
    win_b = i_b[32'(win_idx)*16 +: 16];
  end

  // The arithmetic right shift on a signed value rounds toward -infinity.
  always_comb begin
    prod    = s1_a * s1_b;
    shifted = prod >>> SHIFT;
    if (shifted > 32'sd32767)
      sat = 16'h7fff;
    else if (shifted < -32'sd32768)
      sat = 16'h8000;
    else
      sat = 16'(shifted);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_owner <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      ptr      <= IDW'(N_REQ - 1);
      o_gnt    <= '0;
      o_ack    <= '0;
      o_result <= '0;
      o_busy   <= 1'b0;
    end else begin
      // S1 load
      s1_valid <= win_found;
      if (win_found) begin
        s1_owner <= win_idx;
        s1_a     <= win_a;
        s1_b     <= win_b;
        ptr      <= win_idx;
        o_gnt    <= N_REQ'(1) << win_idx;
      end else begin
        o_gnt    <= '0;
      end
      // S2 load. The S2 owner one-hot is exactly the previous S1 one-hot.
      o_ack <= o_gnt;
      if (s1_valid)
        o_result <= sat;
      // Next S1 valid OR next S2 valid.
      o_busy <= win_found | s1_valid;
    end
  end

endmodule

// File: tb/tb_fx_mul_arbiter.sv
module tb_fx_mul_arbiter;

  localparam int N = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [16*N-1:0] a_bus;
  logic [16*N-1:0] b_bus;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic [15:0]     result;
  logic            busy;

  logic [15:0]     a_op [N];
  logic [15:0]     b_op [N];

  int vectors;
  int miscompares;

  fx_mul_arbiter #(.N_REQ(N), .SHIFT(15)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .i_a      (a_bus),
    .i_b      (b_bus),
    .o_gnt    (gnt),
    .o_ack    (ack),
    .o_result (result),
    .o_busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    a_bus = '0;
    b_bus = '0;
    for (int k = 0; k < N; k++) begin
      a_bus[16*k +: 16] = a_op[k];
      b_bus[16*k +: 16] = b_op[k];
    end
  end

  // ---------------- reference model ----------------
  int          m_last;      // index of the most recent winner
  int          m_inflight;  // requester whose operands were captured last edge, -1 if none
  logic [15:0] m_inflight_res;
  logic [15:0] m_out;
  logic [N-1:0] exp_gnt;
  logic [N-1:0] exp_ack;
  logic [15:0]  exp_res;
  logic         exp_busy;

  // Q15 multiply: exact product, floor division by 2^15, clamp to int16.
  function automatic logic [15:0] ref_mul(input logic signed [15:0] a,
                                          input logic signed [15:0] b);
    longint p, q;
    p = longint'(a) * longint'(b);
    q = p / 32768;
    if ((p % 32768) != 0 && p < 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic model_reset();
    m_last     = N - 1;
    m_inflight = -1;
    m_out      = '0;
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_edge();
    int w;
    w = -1;
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (m_last + i) % N;
      if (w < 0 && req[c] && c != m_inflight) w = c;
    end
    exp_ack = '0;
    if (m_inflight >= 0) begin
      exp_ack = N'(1) << m_inflight;
      m_out   = m_inflight_res;
    end
    exp_res  = m_out;
    exp_busy = (w >= 0) || (m_inflight >= 0);
    exp_gnt  = '0;
    if (w >= 0) begin
      exp_gnt        = N'(1) << w;
      m_inflight_res = ref_mul(a_op[w], b_op[w]);
      m_last         = w;
    end
    m_inflight = w;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("gnt",    32'(gnt),    32'(exp_gnt));
    chk("ack",    32'(ack),    32'(exp_ack));
    chk("result", 32'(result), 32'(exp_res));
    chk("busy",   32'(busy),   32'(exp_busy));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    #1;
    model_reset();
    chk("rst_gnt",    32'(gnt),    0);
    chk("rst_ack",    32'(ack),    0);
    chk("rst_result", 32'(result), 0);
    chk("rst_busy",   32'(busy),   0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
  } vec_t;

  vec_t tbl [8];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    req         = '0;
    for (int k = 0; k < N; k++) begin
      a_op[k] = '0;
      b_op[k] = '0;
    end
    model_reset();

    tbl[0] = '{0, 16'd16384, 16'd16384, 16'd8192};
    tbl[1] = '{1, 16'h8000,  16'h8000,  16'd32767};
    tbl[2] = '{1, 16'h8000,  16'h7fff,  16'h8001};   // -32767
    tbl[3] = '{2, 16'hffff,  16'd1,     16'hffff};   // -1 via floor
    tbl[4] = '{2, 16'd1,     16'd1,     16'd0};
    tbl[5] = '{3, 16'h7fff,  16'h7fff,  16'd32766};
    tbl[6] = '{3, 16'h8000,  16'd1,     16'hffff};
    tbl[7] = '{0, 16'd100,   16'hff38,  16'hffff};   // 100 * -200

    do_reset();

    // Directed arithmetic table, one requester at a time.
    for (int t = 0; t < 8; t++) begin
      a_op[tbl[t].k] = tbl[t].a;
      b_op[tbl[t].k] = tbl[t].b;
      req[tbl[t].k]  = 1'b1;
      step();
      chk("tbl_gnt", 32'(gnt), 32'(N'(1) << tbl[t].k));
      req[tbl[t].k] = 1'b0;
      step();
      chk("tbl_ack", 32'(ack),    32'(N'(1) << tbl[t].k));
      chk("tbl_res", 32'(result), 32'(tbl[t].res));
      step();
    end

    // All four from reset: grants 0,1,2,3 back to back.
    do_reset();
    for (int k = 0; k < N; k++) begin
      a_op[k] = 16'(k * 4096);
      b_op[k] = 16'd16384;
    end
    req = '1;
    for (int i = 0; i < N; i++) begin
      step();
      chk("seq_gnt", 32'(gnt), 32'(N'(1) << i));
      chk("seq_busy", 32'(busy), 1);
      req = req & ~gnt;
    end
    step();
    chk("seq_last_ack", 32'(ack), 32'b1000);
    step();

    // After requester 1 wins, 3 beats 1 when both request.
    req = 4'b0010;
    step();
    chk("rr_first", 32'(gnt), 32'b0010);
    req = '0;
    step();
    req = 4'b1010;
    step();
    chk("rr_three", 32'(gnt), 32'b1000);
    req[3] = 1'b0;
    step();
    chk("rr_one", 32'(gnt), 32'b0010);
    req = '0;
    step();
    step();

    // Reset while S1 is valid.
    req = 4'b0001;
    step();
    rst_n = 1'b0;
    req   = '0;
    #1;
    model_reset();
    chk("mid_rst_gnt",    32'(gnt),    0);
    chk("mid_rst_ack",    32'(ack),    0);
    chk("mid_rst_result", 32'(result), 0);
    chk("mid_rst_busy",   32'(busy),   0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    req = 4'b0100;
    step();
    chk("post_rst_gnt", 32'(gnt), 32'b0100);
    req = '0;
    step();
    step();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] seen;
      seen = gnt;
      for (int k = 0; k < N; k++) begin
        if (req[k] && seen[k]) begin
          if ($urandom_range(0, 99) < 70) req[k] = 1'b0;
          else begin
            a_op[k] = 16'($urandom);
            b_op[k] = 16'($urandom);
          end
        end else if (!req[k] && $urandom_range(0, 99) < 40) begin
          req[k] = 1'b1;
          case ($urandom_range(0, 7))
            0:       begin a_op[k] = 16'h8000; b_op[k] = 16'h8000; end
            1:       begin a_op[k] = 16'h7fff; b_op[k] = 16'h8000; end
            default: begin a_op[k] = 16'($urandom); b_op[k] = 16'($urandom); end
          endcase
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fx_mul_arbiter.md
FX_MUL_ARBITER -- requirements
Module: fx_mul_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of effect requesters sharing the multiplier.
REQ-002 The block SHALL have parameter SHIFT, default 15, giving the Q-format right shift applied to the product.
REQ-003 i_clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  N_REQ  request per requester; held high until o_gnt is seen.
REQ-006 i_a  input  16*N_REQ  signed operand A; requester k uses bits [16k+15:16k].
REQ-007 i_b  input  16*N_REQ  signed operand B, same packing as i_a.
REQ-008 o_gnt  output  N_REQ  one-hot; high for one cycle when requester k's operands have been captured.
REQ-009 o_ack  output  N_REQ  one-hot; high for one cycle while o_result holds requester k's result.
REQ-010 o_result  output  16  signed, scaled and saturated product.
REQ-011 o_busy  output  1  high while any pipeline stage holds a valid operation.

Function
REQ-012 The pipeline SHALL have two stages: S1 holds captured operands, owner id and valid bit; S2 holds the result, owner id and valid bit.
REQ-013 Requester k SHALL be eligible at an edge when i_req[k]=1 and S1 is not valid with owner k.
REQ-014 At each edge with at least one eligible requester, exactly one winner SHALL be chosen by round robin: search from (ptr+1) mod N_REQ upward, wrapping.
REQ-015 On a win, the winner's i_a/i_b and id SHALL load S1, S1 valid SHALL be set, and ptr SHALL become the winner index.
REQ-016 With no eligible requester, S1 valid SHALL clear and ptr SHALL hold.
REQ-017 o_gnt SHALL equal the one-hot of S1 owner when S1 is valid, else zero (registered, never combinational from i_req).
REQ-018 At each edge, S2 SHALL load from S1: valid, owner, and the result of the arithmetic in REQ-019/020.
REQ-019 Arithmetic: full 32-bit signed product a*b, then arithmetic (sign-preserving, floor) right shift by SHIFT.
REQ-020 The shifted value SHALL saturate to [-32768, 32767] before loading o_result.
REQ-021 o_ack SHALL be the one-hot of S2 owner when S2 is valid, else zero; o_result SHALL hold its last value when S2 is not valid.
REQ-022 Latency: a requester winning at edge E sees o_gnt after E and o_ack/o_result after E+1; a new operation SHALL issue on every edge (throughput 1/cycle).
REQ-023 Simultaneous S1 load and S2 load at the same edge SHALL both occur; no stall condition exists.
REQ-024 A requester keeping i_req high after o_gnt SHALL be granted again no earlier than two edges after its previous win; no operation is dropped or duplicated.
REQ-025 o_busy SHALL be S1 valid OR S2 valid.

Reset
REQ-026 While i_rst_n=0: o_gnt=0, o_ack=0, o_result=0, o_busy=0, S1/S2 valid=0, ptr=N_REQ-1.
REQ-027 Reset mid-operation SHALL discard in-flight operations; no o_ack for them SHALL appear after release.
REQ-028 The first arbitration after reset SHALL favour requester 0.

Verification
REQ-029 req0 only, a=16384, b=16384 -> o_gnt=0001 one cycle, next cycle o_ack=0001, o_result=8192.
REQ-030 req1, a=-32768, b=-32768 -> o_result=32767 (saturated); then a=-32768, b=32767 -> o_result=-32767.
REQ-031 req2, a=-1, b=1 -> o_result=-1 (floor shift); a=1, b=1 -> o_result=0.
REQ-032 All four requesting from reset, each dropping req on gnt -> grants 0,1,2,3 on consecutive cycles; acks trail by one cycle; o_busy high throughout.
REQ-033 After requester 1 wins, req1 and req3 asserted together -> 3 granted before 1.
REQ-034 Reset asserted while S1 valid -> all outputs 0 immediately, no ack after release; then req2 alone -> o_gnt=0100.
